// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer defaults, colour type and FSM state encoding
//   FB_W_DEF / FB_H_DEF : default framebuffer size in pixels
//   color_t             : RRRGGGBB pixel byte
//   state_t             : arbiter FSM states (CLEAR exists only with FB_CLEAR_EN)
package fb_pkg;
   localparam int FB_W_DEF = 96;
   localparam int FB_H_DEF = 64;
   typedef logic [7:0] color_t;
   typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;
endpackage

// File: rtl/fb_ram.sv
// fb_ram: simple dual-port framebuffer memory, one write port, one registered read port
//   clk     : clock
//   i_we    : write enable, i_waddr / i_wdata write address and data
//   i_raddr : read address, o_rdata registered read data (old data on collision)
module fb_ram
   import fb_pkg::*;
#(
   parameter int DEPTH = FB_W_DEF * FB_H_DEF,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  color_t        i_wdata,
   input  logic [AW-1:0] i_raddr,
   output color_t        o_rdata
);
   color_t r_mem [DEPTH];
   // no reset on the array or read register so it maps onto block RAM
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      o_rdata <= r_mem[i_raddr];
   end
endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: two-requester round-robin framebuffer write arbiter with video read port
//   clk, resetn                    : clock, asynchronous active-low reset
//   w0_* / w1_*                    : write requesters (valid/ready, x, y, colour)
//   rd_x, rd_y, rd_color           : video read port, 1-cycle latency, 0 when out of range
//   drop_cnt                       : saturating count of out-of-range writes
//   clear_start/color, clear_busy/done : framebuffer fill, present only with macro FB_CLEAR_EN
module fb_write_arbiter
   import fb_pkg::*;
#(
   parameter int FB_W = FB_W_DEF,
   parameter int FB_H = FB_H_DEF
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       w0_valid,
   output logic       w0_ready,
   input  logic [7:0] w0_x,
   input  logic [5:0] w0_y,
   input  color_t     w0_color,
   input  logic       w1_valid,
   output logic       w1_ready,
   input  logic [7:0] w1_x,
   input  logic [5:0] w1_y,
   input  color_t     w1_color,
   input  logic [7:0] rd_x,
   input  logic [5:0] rd_y,
   output color_t     rd_color,
`ifdef FB_CLEAR_EN
   input  logic       clear_start,
   input  color_t     clear_color,
   output logic       clear_busy,
   output logic       clear_done,
`endif
   output logic [7:0] drop_cnt
);
   localparam int DEPTH = FB_W * FB_H;
   localparam int AW    = $clog2(DEPTH);

   logic          r_prio1;
   logic          r_rd_valid;
   logic [7:0]    r_drop;
   logic          w_grant0, w_grant1, w_idle, w_fire, w_win, w_rin, w_we;
   logic [7:0]    w_wx;
   logic [5:0]    w_wy;
   color_t        w_wc, w_wdata, w_q;
   logic [AW-1:0] w_addr, w_waddr, w_raddr;

   // r_prio1 set means requester 1 wins a tie (requester 0 was served last)
   assign w_grant0 = w0_valid & (~w1_valid | ~r_prio1);
   assign w_grant1 = w1_valid & (~w0_valid | r_prio1);
   assign w0_ready = w_grant0 & w_idle;
   assign w1_ready = w_grant1 & w_idle;
   assign w_fire   = w0_ready | w1_ready;

   assign w_wx   = w_grant1 ? w1_x : w0_x;
   assign w_wy   = w_grant1 ? w1_y : w0_y;
   assign w_wc   = w_grant1 ? w1_color : w0_color;
   assign w_win  = (32'(w_wx) < FB_W) && (32'(w_wy) < FB_H);
   assign w_addr = AW'(32'(w_wy) * FB_W + 32'(w_wx));

   assign w_rin   = (32'(rd_x) < FB_W) && (32'(rd_y) < FB_H);
   assign w_raddr = w_rin ? AW'(32'(rd_y) * FB_W + 32'(rd_x)) : '0;

`ifdef FB_CLEAR_EN
   state_t        r_state, w_next;
   logic [AW-1:0] r_cnt;
   color_t        r_clr_color;
   logic          r_done;
   logic          w_last;

   assign w_last = r_cnt == AW'(DEPTH - 1);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (r_state == ST_IDLE && clear_start) w_next = ST_CLEAR;
      if (r_state == ST_CLEAR && w_last)     w_next = ST_IDLE;
   end

   always_comb begin
      w_idle     = r_state == ST_IDLE;
      clear_busy = r_state == ST_CLEAR;
      clear_done = r_done;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt       <= '0;
         r_clr_color <= '0;
         r_done      <= 1'b0;
      end else begin
         r_cnt       <= (clear_busy && !w_last) ? r_cnt + 1'b1 : '0;
         r_clr_color <= (w_idle && clear_start) ? clear_color : r_clr_color;
         r_done      <= clear_busy && w_last;
      end
   end

   assign w_we    = clear_busy | (w_fire & w_win);
   assign w_waddr = clear_busy ? r_cnt : w_addr;
   assign w_wdata = clear_busy ? r_clr_color : w_wc;
`else
   assign w_idle  = 1'b1;
   assign w_we    = w_fire & w_win;
   assign w_waddr = w_addr;
   assign w_wdata = w_wc;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_prio1    <= 1'b0;
         r_rd_valid <= 1'b0;
         r_drop     <= '0;
      end else begin
         r_rd_valid <= w_rin;
         if (w_fire) r_prio1 <= w0_ready;
         if (w_fire && !w_win && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      end
   end

   // RAM read register has no reset; the valid flag masks it to 0 after reset and for out-of-range reads
   assign rd_color = r_rd_valid ? w_q : 8'h00;
   assign drop_cnt = r_drop;

   fb_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_q)
   );
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: vector table, randomized reference-model and corner-sequence bench for fb_write_arbiter
module tb_fb_write_arbiter;
   localparam int W = 96;
   localparam int H = 64;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       w0_valid = 1'b0, w1_valid = 1'b0;
   logic       w0_ready, w1_ready;
   logic [7:0] w0_x = '0, w1_x = '0, rd_x = '0;
   logic [5:0] w0_y = '0, w1_y = '0, rd_y = '0;
   logic [7:0] w0_color = '0, w1_color = '0, rd_color, drop_cnt;
`ifdef FB_CLEAR_EN
   logic       clear_start = 1'b0;
   logic [7:0] clear_color = '0;
   logic       clear_busy, clear_done;
`endif

   int checks = 0;
   int errors = 0;
   int mem [W*H];
   int mdrop = 0;
   int last = 1;

   typedef struct {
      bit v0, v1;
      int x0, y0, c0, x1, y1, c1;
      bit r0, r1;
   } vec_t;
   vec_t tv [9];

   fb_write_arbiter #(.FB_W(W), .FB_H(H)) dut (
      .clk(clk), .resetn(resetn),
      .w0_valid(w0_valid), .w0_ready(w0_ready), .w0_x(w0_x), .w0_y(w0_y), .w0_color(w0_color),
      .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_x(w1_x), .w1_y(w1_y), .w1_color(w1_color),
      .rd_x(rd_x), .rd_y(rd_y), .rd_color(rd_color),
`ifdef FB_CLEAR_EN
      .clear_start(clear_start), .clear_color(clear_color),
      .clear_busy(clear_busy), .clear_done(clear_done),
`endif
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit inr(input int x, input int y);
      return x < W && y < H;
   endfunction

   // reference: an accepted write either lands in the pixel array or bumps the saturating drop count
   task automatic mwrite(input int x, input int y, input int c);
      if (inr(x, y)) mem[y*W + x] = c;
      else if (mdrop < 255) mdrop++;
   endtask

   task automatic do_reset();
      w0_valid = 0; w1_valid = 0;
      resetn = 0;
      #1;
      chk("reset_rd_color", int'(rd_color), 0);
      chk("reset_drop_cnt", int'(drop_cnt), 0);
      step();
      resetn = 1;
      mdrop = 0;
      last = 1;
      step();
   endtask

   task automatic rd_chk(input string name, input int x, input int y);
      w0_valid = 0; w1_valid = 0;
      rd_x = 8'(x); rd_y = 6'(y);
      step();
      chk(name, int'(rd_color), inr(x, y) ? mem[y*W + x] : 0);
   endtask

   task automatic set_w0(input bit v, input int x, input int y, input int c);
      w0_valid = v; w0_x = 8'(x); w0_y = 6'(y); w0_color = 8'(c);
   endtask

   task automatic set_w1(input bit v, input int x, input int y, input int c);
      w1_valid = v; w1_x = 8'(x); w1_y = 6'(y); w1_color = 8'(c);
   endtask

   initial begin
      tv[0] = '{1, 1, 20, 2, 'hA1, 21, 2, 'hB2, 1, 0};
      tv[1] = '{1, 1, 22, 2, 'hA3, 23, 2, 'hB4, 0, 1};
      tv[2] = '{1, 1, 24, 2, 'hA5, 25, 2, 'hB6, 1, 0};
      tv[3] = '{1, 1, 26, 2, 'hA7, 27, 2, 'hB8, 0, 1};
      tv[4] = '{0, 0, 30, 4, 'h11, 31, 4, 'h22, 0, 0};
      tv[5] = '{1, 0,  5, 3, 'hE0,  0, 0, 'h00, 1, 0};
      tv[6] = '{0, 1,  0, 0, 'h00, 96, 0, 'hFF, 0, 1};
      tv[7] = '{0, 1,  0, 0, 'h00, 200, 5, 'hFF, 0, 1};
      tv[8] = '{1, 1, 40, 9, 'h5A, 41, 9, 'hA5, 1, 0};

      #1;
      chk("reset_rd_color", int'(rd_color), 0);
      chk("reset_drop_cnt", int'(drop_cnt), 0);
      chk("reset_w0_ready", int'(w0_ready), 0);
      chk("reset_w1_ready", int'(w1_ready), 0);
`ifdef FB_CLEAR_EN
      chk("reset_clear_busy", int'(clear_busy), 0);
      chk("reset_clear_done", int'(clear_done), 0);
`endif
      step();
      resetn = 1;
      step();

      // fill every pixel with a known pattern so later reads have a defined reference
      for (int a = 0; a < W*H; a++) begin
         set_w0(1, a % W, a / W, (a * 7 + 3) & 255);
         #1;
         chk("prefill_w0_ready", int'(w0_ready), 1);
         mwrite(a % W, a / W, (a * 7 + 3) & 255);
         step();
      end
      do_reset();

      for (int i = 0; i < 9; i++) begin
         set_w0(tv[i].v0, tv[i].x0, tv[i].y0, tv[i].c0);
         set_w1(tv[i].v1, tv[i].x1, tv[i].y1, tv[i].c1);
         #1;
         chk($sformatf("vec%0d_w0_ready", i), int'(w0_ready), int'(tv[i].r0));
         chk($sformatf("vec%0d_w1_ready", i), int'(w1_ready), int'(tv[i].r1));
         if (tv[i].r0) begin mwrite(tv[i].x0, tv[i].y0, tv[i].c0); last = 0; end
         if (tv[i].r1) begin mwrite(tv[i].x1, tv[i].y1, tv[i].c1); last = 1; end
         step();
      end
      chk("vec_drop_cnt", int'(drop_cnt), 2);
      rd_chk("read_5_3", 5, 3);
      chk("read_5_3_value", int'(rd_color), 'hE0);
      for (int i = 0; i < 4; i++) begin
         rd_chk("vec_readback_w0", tv[i].x0, tv[i].y0);
         rd_chk("vec_readback_w1", tv[i].x1, tv[i].y1);
      end
      rd_chk("drop_no_alias_0_1", 0, 1);

      for (int n = 0; n < 600; n++) begin
         int x0, y0, c0, x1, y1, c1, rx, ry, erd;
         bit v0, v1, g0, g1;
         v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
         x0 = $urandom_range(0, 110); y0 = $urandom_range(0, 63); c0 = $urandom_range(0, 255);
         x1 = $urandom_range(0, 110); y1 = $urandom_range(0, 63); c1 = $urandom_range(0, 255);
         rx = $urandom_range(0, 110); ry = $urandom_range(0, 63);
         set_w0(v0, x0, y0, c0);
         set_w1(v1, x1, y1, c1);
         rd_x = 8'(rx); rd_y = 6'(ry);
         // tie goes to whoever was not served by the previous transfer
         g0 = v0 && (!v1 || last == 1);
         g1 = v1 && !g0;
         #1;
         chk("rand_w0_ready", int'(w0_ready), int'(g0));
         chk("rand_w1_ready", int'(w1_ready), int'(g1));
         erd = inr(rx, ry) ? mem[ry*W + rx] : 0;
         if (g0) begin mwrite(x0, y0, c0); last = 0; end
         if (g1) begin mwrite(x1, y1, c1); last = 1; end
         step();
         chk("rand_rd_color", int'(rd_color), erd);
      end
      chk("rand_drop_cnt", int'(drop_cnt), mdrop);
      for (int a = 0; a < W*H; a++) rd_chk("sweep_read", a % W, a / W);

      for (int n = 0; n < 300; n++) begin
         set_w1(1, 96, 0, 'hFF);
         #1;
         chk("sat_w1_ready", int'(w1_ready), 1);
         mwrite(96, 0, 'hFF);
         step();
      end
      w1_valid = 0;
      chk("sat_drop_cnt", int'(drop_cnt), 255);
      rd_chk("sat_no_alias_0_1", 0, 1);
      rd_chk("sat_row0_end", 95, 0);

      set_w0(1, 0, 0, 'h1C);
      mwrite(0, 0, 'h1C);
      step();
      set_w0(1, 0, 0, 'h03);
      rd_x = 0; rd_y = 0;
      step();
      chk("rw_same_cycle_old", int'(rd_color), 'h1C);
      mwrite(0, 0, 'h03);
      rd_chk("rw_next_read_new", 0, 0);

`ifdef FB_CLEAR_EN
      begin
         int busy_n, done_n;
         clear_color = 8'h02;
         clear_start = 1;
         set_w0(1, 1, 1, 'h55);
         #1;
         chk("clear_coincident_w0_ready", int'(w0_ready), 1);
         step();
         clear_start = 0;
         clear_color = 8'h77;
         busy_n = 0; done_n = 0;
         while (clear_busy && busy_n < 7000) begin
            chk("clear_w0_ready_held", int'(w0_ready), 0);
            if (clear_done) done_n++;
            if (busy_n == 10) clear_start = 1;
            if (busy_n == 11) clear_start = 0;
            busy_n++;
            step();
         end
         w0_valid = 0;
         chk("clear_busy_cycles", busy_n, W*H);
         chk("clear_done_during_busy", done_n, 0);
         chk("clear_done_pulse", int'(clear_done), 1);
         step();
         chk("clear_done_single", int'(clear_done), 0);
         chk("clear_not_restarted", int'(clear_busy), 0);
         for (int a = 0; a < W*H; a++) mem[a] = 'h02;
         for (int a = 0; a < W*H; a++) rd_chk("clear_read", a % W, a / W);

         clear_start = 1;
         step();
         clear_start = 0;
         for (int n = 0; n < 100; n++) step();
         chk("abort_busy_before", int'(clear_busy), 1);
         resetn = 0;
         #1;
         chk("abort_busy_now", int'(clear_busy), 0);
         chk("abort_done_now", int'(clear_done), 0);
         step();
         resetn = 1;
         done_n = 0;
         for (int n = 0; n < 8; n++) begin
            if (clear_done || clear_busy) done_n++;
            step();
         end
         chk("abort_no_done", done_n, 0);
         set_w0(1, 7, 7, 'h99);
         #1;
         chk("abort_w0_ready", int'(w0_ready), 1);
         mwrite(7, 7, 'h99);
         step();
         rd_chk("abort_write_read", 7, 7);
      end
`endif

      do_reset();
      rd_chk("final_oor_read", 100, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
